fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core, directly upstream of the Fetch/Decode pipeline register. It owns the fetch PC and issues in-order requests to a variable-latency instruction memory with a req/gnt/rvalid handshake. Returned words are queued with their PCs in a 2-entry buffer and presented to the Fetch/Decode register as `{instr, PC, PC+4, valid}`. On an Execute-stage redirect, the buffer is flushed and responses still in flight are discarded.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage; owns the fetch PC, issues req/gnt/rvalid
// requests to imem and buffers returned words in a 2-entry FIFO.
// Ports: i_clk, i_rstn (async low); imem o_imem_req/o_imem_addr,
// i_imem_gnt/i_imem_rvalid/i_imem_rdata; redirect i_PCSrcE/i_PCTargetE;
// stall i_StallF_en; head o_instrF/o_PCF/o_PCPlus4F/o_validF.
// Optional FETCH_BYPASS_EN: forward a response straight to the outputs
// when the buffer is empty.
`ifndef XLEN
`define XLEN 32
`endif

module fetch_unit #(
  parameter logic [`XLEN-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  output logic              o_imem_req,
  output logic [`XLEN-1:0]  o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [`XLEN-1:0]  i_imem_rdata,
  input  logic              i_PCSrcE,
  input  logic [`XLEN-1:0]  i_PCTargetE,
  input  logic              i_StallF_en,
  output logic [`XLEN-1:0]  o_instrF,
  output logic [`XLEN-1:0]  o_PCF,
  output logic [`XLEN-1:0]  o_PCPlus4F,
  output logic              o_validF
);

  localparam int XL = `XLEN;

  logic [XL-1:0] r_fpc;
  logic [1:0]    r_outs;
  logic [1:0]    r_kill;
  logic [1:0]    r_cnt;
  logic [XL-1:0] r_epc [0:1];
  logic [XL-1:0] r_ein [0:1];
  logic [XL-1:0] r_apc [0:1];
  logic          r_awr;
  logic          r_ard;

  logic [2:0]    w_occ;
  logic          w_req;
  logic          w_acc;
  logic          w_rsp;
  logic          w_keep;
  logic          w_byp;
  logic          w_hvalid;
  logic          w_valid;
  logic          w_pop;
  logic          w_fpop;
  logic          w_push;
  logic          w_widx;
  logic [1:0]    w_outs_nx;
  logic [XL-1:0] w_raddr;
  logic [XL-1:0] w_hpc;
  logic [XL-1:0] w_hin;
  logic          w_unused;

  assign w_unused = ^i_PCTargetE[1:0];

  // Credit check: in-flight plus buffered never exceeds the buffer depth.
  assign w_occ = {1'b0, r_outs} + {1'b0, r_cnt};
  assign w_req = i_rstn && !i_PCSrcE && (w_occ < 3'd2);
  assign w_acc = w_req && i_imem_gnt;

  // Stray rvalid with nothing outstanding is ignored.
  assign w_rsp   = i_imem_rvalid && (r_outs != 2'd0);
  assign w_raddr = r_apc[r_ard];
  assign w_keep  = w_rsp && (r_kill == 2'd0) && !i_PCSrcE;

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_keep && (r_cnt == 2'd0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_hvalid = (r_cnt != 2'd0);
  assign w_valid  = w_hvalid || w_byp;
  assign w_hpc    = w_hvalid ? r_epc[0] : w_raddr;
  assign w_hin    = w_hvalid ? r_ein[0] : i_imem_rdata;

  assign w_pop  = w_valid && !i_StallF_en && !i_PCSrcE;
  assign w_fpop = w_pop && w_hvalid;
  // A bypassed word consumed in the same cycle never enters the buffer.
  assign w_push = w_keep && !(w_byp && w_pop);
  // Slot for the new word after any pop-shift this cycle.
  assign w_widx = r_cnt[0] && !w_fpop;

  assign w_outs_nx = r_outs + {1'b0, w_acc} - {1'b0, w_rsp};

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fpc;
  assign o_validF    = w_valid;
  assign o_PCF       = w_valid ? w_hpc : '0;
  assign o_instrF    = w_valid ? w_hin : '0;
  assign o_PCPlus4F  = w_valid ? (w_hpc + 32'd4) : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_fpc    <= RESET_PC;
      r_outs   <= 2'd0;
      r_kill   <= 2'd0;
      r_cnt    <= 2'd0;
      r_awr    <= 1'b0;
      r_ard    <= 1'b0;
      r_epc[0] <= '0;
      r_epc[1] <= '0;
      r_ein[0] <= '0;
      r_ein[1] <= '0;
      r_apc[0] <= '0;
      r_apc[1] <= '0;
    end else begin
      r_outs <= w_outs_nx;
      if (w_acc) begin
        r_apc[r_awr] <= r_fpc;
        r_awr        <= ~r_awr;
      end
      if (w_rsp) r_ard <= ~r_ard;
      if (i_PCSrcE) begin
        r_fpc  <= {i_PCTargetE[XL-1:2], 2'b00};
        r_kill <= w_outs_nx;
        r_cnt  <= 2'd0;
      end else begin
        if (w_acc) r_fpc <= r_fpc + 32'd4;
        if (w_rsp && (r_kill != 2'd0)) r_kill <= r_kill - 2'd1;
        r_cnt <= r_cnt - {1'b0, w_fpop} + {1'b0, w_push};
        if (w_fpop) begin
          r_epc[0] <= r_epc[1];
          r_ein[0] <= r_ein[1];
        end
        if (w_push) begin
          r_epc[w_widx] <= w_raddr;
          r_ein[w_widx] <= i_imem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random bench for fetch_unit with a
// variable-latency memory model and an in-order PC scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'hFFFF_FFF8;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        pcsrc;
  logic [31:0] target;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pcf;
  logic [31:0] pc4;
  logic        validF;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (gnt),
    .i_imem_rvalid(rvalid),
    .i_imem_rdata (rdata),
    .i_PCSrcE     (pcsrc),
    .i_PCTargetE  (target),
    .i_StallF_en  (stall),
    .o_instrF     (instr),
    .o_PCF        (pcf),
    .o_PCPlus4F   (pc4),
    .o_validF     (validF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] sb_q[$];
  logic [31:0] exp_addr;
  int          kill_m;
  int          cyc;
  int          lat;
  int          last_due;
  int          n_vec;
  int          n_err;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    bit          rsp;
    bit          byp;
    bit          keep;
    bit          ereq;
    bit          evld;
    bit          pop;
    int          due;
    logic [31:0] ra;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    ra  = rsp ? mem_q[0].a : 32'h0;
    rvalid = rsp;
    rdata  = rsp ? instr_of(ra) : 32'h0;
    #4;
    ereq = !pcsrc && (mem_q.size() + sb_q.size() < 2);
    chk("req", {31'b0, imem_req}, {31'b0, ereq});
    if (ereq) chk("addr", imem_addr, exp_addr);
    keep = rsp && (kill_m == 0) && !pcsrc;
    byp  = BYP && keep && (sb_q.size() == 0);
    if (byp) sb_q.push_back(ra);
    evld = (sb_q.size() > 0);
    chk("validF", {31'b0, validF}, {31'b0, evld});
    if (evld) begin
      chk("pcF", pcf, sb_q[0]);
      chk("instrF", instr, instr_of(sb_q[0]));
      chk("pc4F", pc4, sb_q[0] + 32'd4);
    end else begin
      chk("pcF_zero", pcf, 32'h0);
      chk("instrF_zero", instr, 32'h0);
    end
    pop = evld && !stall && !pcsrc;
    if (pop) void'(sb_q.pop_front());
    if (keep && !byp) sb_q.push_back(ra);
    if (rsp) void'(mem_q.pop_front());
    if (pcsrc) begin
      kill_m = mem_q.size();
      sb_q.delete();
      exp_addr = {target[31:2], 2'b00};
    end else begin
      if (rsp && kill_m > 0) kill_m--;
      if (ereq && gnt) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{a: exp_addr, due: due});
        exp_addr = exp_addr + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    mem_q.delete();
    sb_q.delete();
    kill_m   = 0;
    exp_addr = RPC;
    last_due = 0;
    rvalid   = 1'b0;
    rdata    = 32'h0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, "_valid"}, {31'b0, validF}, 32'h0);
    chk({tag, "_pc"}, pcf, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc4"}, pc4, 32'h0);
  endtask

  initial begin
    bit found;
    n_vec  = 0;
    n_err  = 0;
    cyc    = 0;
    lat    = 1;
    rstn   = 1'b0;
    gnt    = 1'b1;
    pcsrc  = 1'b0;
    target = 32'h0;
    stall  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rstn = 1'b1;

    // reset fetch and wrap, single-cycle memory
    repeat (8) tick();

    // stall holds the head, credits limit requests
    stall = 1'b1;
    repeat (5) tick();
    stall = 1'b0;
    repeat (6) tick();

    // redirect with two requests in flight on a 3-cycle memory
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_q.size() == 2 && !(mem_q[0].due <= cyc)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("redir2_found", {31'b0, found}, 32'h1);
    pcsrc  = 1'b1;
    target = 32'h0000_2002;
    tick();
    pcsrc = 1'b0;
    chk("redir2_kill", kill_m, 2);
    repeat (12) tick();

    // redirect colliding with a response and a pop
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc && sb_q.size() > 0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("collide_found", {31'b0, found}, 32'h1);
    pcsrc  = 1'b1;
    target = 32'h0000_3006;
    tick();
    pcsrc = 1'b0;
    repeat (10) tick();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      stall  = ($urandom % 10) < 3;
      gnt    = ($urandom % 10) < 7;
      pcsrc  = ($urandom % 20) == 0;
      target = $urandom;
      lat    = $urandom_range(1, 3);
      tick();
    end
    stall = 1'b0;
    gnt   = 1'b1;
    pcsrc = 1'b0;
    lat   = 1;
    repeat (4) tick();

    // asynchronous reset mid-run
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outs("areset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
